coin_payer: RTL and testbench
=============================

Name: coin_payer

Overview:
Customer-side initiator for the 2-bit coin interface of the drink vending machine (price 2 yuan, coins 5 jiao / 1 yuan). On a start request it checks a wallet of coin counts against PRICE and inserts coins one per cycle on coin[1:0]. It then waits for the machine's sell/change response and reports completion, change received and coins spent. Used as the stimulus/driver side in integration benches and as a reusable payment agent.

Parameters:
PRICE, 4, price in 0.5-yuan units; legal range 1..15.
TIMEOUT, 3, max WAIT cycles allowed without sell before err; legal range 1..15.

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  payment request; sampled only in IDLE
n05  input  4  available 5-jiao coins; sampled with start
n10  input  4  available 1-yuan coins; sampled with start
sell  input  1  machine response: drink sold
change  input  2  machine response: 2'b01 = 5 jiao change returned
coin  output  2  registered coin code: 00 none, 01 = 5 jiao, 10 = 1 yuan; never 11
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful sale
err  output  1  one-cycle pulse on insufficient funds or timeout
got_change  output  1  level; 1 if change == 01 with sell in the last sale, held until next start
spent05  output  4  5-jiao coins inserted in the current/last transaction
spent10  output  4  1-yuan coins inserted in the current/last transaction

Behaviour:
- Reset (async, rstn low): state IDLE; coin=00, busy=0, done=0, err=0, got_change=0, spent05=0, spent10=0, internal wallet/remaining/timer = 0. Reset mid-payment aborts at once; coin drops to 00 without waiting for a clock.
- States: IDLE, CHECK, PAY, WAIT.
- IDLE: on start=1, latch w05=n05, w10=n10, rem=PRICE (5 bits); clear spent05/spent10/got_change -> CHECK. start in any other state is ignored.
- CHECK (1 cycle, coin=00): funds = w05 + 2*w10 (6 bits, no overflow). If funds < PRICE -> err pulse next cycle, -> IDLE. Otherwise -> PAY.
- PAY: one coin per cycle, chosen by priority:
  (1) w05>0: coin=01, w05--, rem--, spent05++.
  (2) else rem>=2: coin=10, w10--, rem-=2, spent10++.
  (3) else (rem==1, only 1-yuan coins left): coin=10, rem=0 (overpay by 5 jiao), spent10++.
  Coin register updates on the edge that enters/stays in PAY. When rem reaches 0 on that edge, the next state is WAIT and coin returns to 00 on the following edge. Back-to-back coins have no idle gap.
- WAIT: coin=00; timer counts from 0 each cycle. sell=1 -> done pulse, got_change=(change==2'b01), -> IDLE. If timer reaches TIMEOUT without sell -> err pulse, -> IDLE. The machine responds 1 cycle after sampling the last coin, so the default TIMEOUT leaves margin.
- sell/change arriving outside WAIT are ignored.
- done and err never assert in the same cycle. Each is high exactly one cycle, registered.
- spent05/spent10 hold their values after done/err until the next accepted start.

Optional Feature:
COIN_GAP_EN: when defined, PAY inserts one idle cycle (coin=00) between consecutive coins via a PAY_GAP sub-state. The timer and all other rules are unchanged. When undefined, coins are driven back-to-back as above.

Test Plan:
- PRICE=4, start with n05=4, n10=0 -> coin 01,01,01,01 on 4 consecutive cycles; machine model sells; done=1 one cycle, got_change=0, spent05=4, spent10=0.
- n05=0, n10=2 -> coin 10,10; done; got_change=0; spent10=2.
- n05=1, n10=2 -> coin 01,10,10 (overpay on last); machine returns change=01 with sell; done, got_change=1, spent05=1, spent10=2.
- n05=1, n10=1 (funds 3 < 4) -> no coin ever driven, err pulse 2 cycles after start, busy low again, spent counts 0.
- n05=4, n10=0 with sell held 0 -> after the 4th coin, err pulses after TIMEOUT=3 WAIT cycles, done never asserts. Separately, assert rstn low after the 2nd coin -> coin=00 immediately, all outputs at reset values.
- COIN_GAP_EN defined, n05=2, n10=1 -> coin pattern 01,00,01,00,10; done as normal. Pulse start during busy -> ignored.

Source files
------------

// File: rtl/coin_payer_if.sv
// coin_payer_if: request/response bundle between a payment requester and the
// coin_payer agent. The slave side is the agent; the master side is whoever
// asks for a payment and plays the vending machine's sell/change response.
interface coin_payer_if;
    // request
    logic       start;
    logic [3:0] n05;
    logic [3:0] n10;
    // machine response
    logic       sell;
    logic [1:0] change;
    // agent outputs
    logic [1:0] coin;
    logic       busy;
    logic       done;
    logic       err;
    logic       got_change;
    logic [3:0] spent05;
    logic [3:0] spent10;

    modport master (
        output start, n05, n10, sell, change,
        input  coin, busy, done, err, got_change, spent05, spent10
    );

    modport slave (
        input  start, n05, n10, sell, change,
        output coin, busy, done, err, got_change, spent05, spent10
    );
endinterface

// File: rtl/coin_payer.sv
// coin_payer: customer-side payment agent for the 2-bit coin interface.
// Latches a wallet on start, checks it covers PRICE, feeds coins one per
// cycle (5 jiao first, then 1 yuan, overpaying by 5 jiao if unavoidable),
// then waits up to TIMEOUT cycles for the machine's sell response.
// Optional build macro COIN_GAP_EN: leaves one idle cycle (coin=00) between
// consecutive coins via the PAY_GAP state.
module coin_payer #(
    parameter int PRICE   = 4,  // 0.5-yuan units, 1..15
    parameter int TIMEOUT = 3   // WAIT cycles without sell before err, 1..15
) (
    input  logic     clk,
    input  logic     rstn,
    coin_payer_if.slave bus
);
    localparam logic [4:0] PRICE_W = 5'(PRICE);
    localparam logic [4:0] TO_W    = 5'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PAY     = 3'd2,
        PAY_GAP = 3'd3,
        WAIT    = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] w05;
    logic [3:0] w10;
    logic [4:0] rem;
    logic [3:0] timer;

    logic [1:0] coin_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       chg_q;
    logic [3:0] s05_q;
    logic [3:0] s10_q;

    // funds in 0.5-yuan units; 15 + 2*15 fits in 6 bits
    logic [5:0] funds;
    logic       short;
    assign funds = {2'b00, w05} + {1'b0, w10, 1'b0};
    assign short = funds < {1'b0, PRICE_W};

    logic [1:0] pick;
    logic [3:0] w05_nx;
    logic [3:0] w10_nx;
    logic [4:0] rem_nx;
    logic       emit;

    // Coin choice for this edge: 5 jiao first, then 1 yuan; a lone 5-jiao
    // remainder with no 5-jiao coins left is settled by overpaying with 1 yuan.
    always_comb begin
        pick   = 2'b00;
        w05_nx = w05;
        w10_nx = w10;
        rem_nx = rem;
        if (w05 != 4'd0) begin
            pick   = 2'b01;
            w05_nx = w05 - 4'd1;
            rem_nx = rem - 5'd1;
        end else if (rem >= 5'd2) begin
            pick   = 2'b10;
            w10_nx = w10 - 4'd1;
            rem_nx = rem - 5'd2;
        end else begin
            pick   = 2'b10;
            w10_nx = w10 - 4'd1;
            rem_nx = 5'd0;
        end
    end

    // Whether a coin goes onto the bus at the coming edge.
    always_comb begin
        emit = 1'b0;
        case (state)
            CHECK:   emit = !short;
`ifdef COIN_GAP_EN
            PAY:     emit = 1'b0;
            PAY_GAP: emit = 1'b1;
`else
            PAY:     emit = (rem != 5'd0);
            PAY_GAP: emit = 1'b0;
`endif
            default: emit = 1'b0;
        endcase
    end

    // Payment FSM with registered outputs; coin is nonzero only right after
    // an emitting edge, so async reset clears it immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            w05    <= 4'd0;
            w10    <= 4'd0;
            rem    <= 5'd0;
            timer  <= 4'd0;
            coin_q <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            chg_q  <= 1'b0;
            s05_q  <= 4'd0;
            s10_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            coin_q <= emit ? pick : 2'b00;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        w05    <= bus.n05;
                        w10    <= bus.n10;
                        rem    <= PRICE_W;
                        s05_q  <= 4'd0;
                        s10_q  <= 4'd0;
                        chg_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (short) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state  <= PAY;
                    end
                end
                PAY: begin
                    if (rem == 5'd0) begin
                        timer <= 4'd0;
                        state <= WAIT;
                    end else begin
`ifdef COIN_GAP_EN
                        state <= PAY_GAP;
`else
                        state <= PAY;
`endif
                    end
                end
                PAY_GAP: begin
                    state <= PAY;
                end
                WAIT: begin
                    if (bus.sell) begin
                        done_q <= 1'b1;
                        chg_q  <= (bus.change == 2'b01);
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (({1'b0, timer} + 5'd1) == TO_W) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        timer  <= 4'd0;
                        state  <= IDLE;
                    end else begin
                        timer  <= timer + 4'd1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            if (emit) begin
                w05 <= w05_nx;
                w10 <= w10_nx;
                rem <= rem_nx;
                if (pick == 2'b01) s05_q <= s05_q + 4'd1;
                else               s10_q <= s10_q + 4'd1;
            end
        end
    end

    assign bus.coin       = coin_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.got_change = chg_q;
    assign bus.spent05    = s05_q;
    assign bus.spent10    = s10_q;
endmodule

// File: tb/tb_coin_payer.sv
// tb_coin_payer: randomized bench for coin_payer. A small wallet model
// derives the expected coin stream from the payment rules; a vending machine
// model answers with sell (and change on overpay) one cycle after it has
// counted enough money. Every cycle of every transaction is checked.
module tb_coin_payer;
    localparam int PRICE   = 4;
    localparam int TIMEOUT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    coin_payer_if bus ();

    coin_payer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // wallet model: which coins a payment of PRICE uses, in order
    int exp_q[$];
    int e05, e10;
    bit e_ok, e_chg;

    task automatic build_model(input int a05, input int a10);
        int r, k;
        exp_q.delete();
        e05   = 0;
        e10   = 0;
        e_chg = 1'b0;
        e_ok  = (a05 + 2 * a10) >= PRICE;
        if (e_ok) begin
            e05   = (a05 < PRICE) ? a05 : PRICE;
            r     = PRICE - e05;
            e10   = (r + 1) / 2;
            e_chg = (r % 2) == 1;
            k     = e05 + e10;
            for (int i = 0; i < k; i++) begin
`ifdef COIN_GAP_EN
                if (i > 0) exp_q.push_back(0);
`endif
                exp_q.push_back((i < e05) ? 1 : 2);
            end
        end
    endtask

    task automatic run_txn(input int a05, input int a10, input bit sell_en,
                           input bit noise, input bit dup);
        int   len, end_c, total;
        bit   pend, sold;
        logic [1:0] ec;
        build_model(a05, a10);
        len = exp_q.size();
        if (!e_ok)        end_c = 2;
        else if (sell_en) end_c = len + 3;
        else              end_c = len + 2 + TIMEOUT;
        total = 0;
        pend  = 1'b0;
        sold  = 1'b0;
        @(negedge clk);
        bus.n05   = 4'(a05);
        bus.n10   = 4'(a10);
        bus.start = 1'b1;
        for (int c = 1; c <= end_c + 1; c++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.sell   = 1'b0;
            bus.change = 2'b00;
            if (c == 1) begin
                bus.n05 = 4'($urandom);
                bus.n10 = 4'($urandom);
            end
            if (pend) begin
                bus.sell   = 1'b1;
                bus.change = (total > PRICE) ? 2'b01 : 2'b00;
                pend       = 1'b0;
            end else if (noise && c <= len + 1 && $urandom_range(0, 2) == 0) begin
                bus.sell   = 1'b1;
                bus.change = 2'($urandom);
            end
            if (dup && e_ok && c == 3) begin
                bus.start = 1'b1;
                bus.n05   = 4'($urandom);
                bus.n10   = 4'($urandom);
            end
            ec = 2'b00;
            if (e_ok && c >= 2 && c <= len + 1) ec = 2'(exp_q[c - 2]);
            chk("coin", bus.coin, ec);
            chk("busy", bus.busy, c < end_c);
            chk("done", bus.done, c == end_c && e_ok && sell_en);
            chk("err",  bus.err,  c == end_c && !(e_ok && sell_en));
            if (bus.coin == 2'b01)      total += 1;
            else if (bus.coin == 2'b10) total += 2;
            if (sell_en && !sold && total >= PRICE) begin
                pend = 1'b1;
                sold = 1'b1;
            end
        end
        chk("spent05",    bus.spent05,    e05);
        chk("spent10",    bus.spent10,    e10);
        chk("got_change", bus.got_change, e_ok && sell_en && e_chg);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_coin"},    bus.coin,       0);
        chk({tag, "_busy"},    bus.busy,       0);
        chk({tag, "_done"},    bus.done,       0);
        chk({tag, "_err"},     bus.err,        0);
        chk({tag, "_chg"},     bus.got_change, 0);
        chk({tag, "_spent05"}, bus.spent05,    0);
        chk({tag, "_spent10"}, bus.spent10,    0);
    endtask

    // reset between clock edges right after the 2nd coin must clear at once
    task automatic reset_mid();
        @(negedge clk);
        bus.n05   = 4'd4;
        bus.n10   = 4'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_coin", bus.coin, 2'b01);
        #2 rstn = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_after_coin", bus.coin, 0);
        chk("rst_after_busy", bus.busy, 0);
    endtask

    int a05, a10;

    initial begin
        bus.start  = 1'b0;
        bus.n05    = 4'd0;
        bus.n10    = 4'd0;
        bus.sell   = 1'b0;
        bus.change = 2'b00;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rstn = 1'b1;

        run_txn(4, 0, 1'b1, 1'b0, 1'b0);
        run_txn(0, 2, 1'b1, 1'b0, 1'b0);
        run_txn(1, 2, 1'b1, 1'b0, 1'b0);
        run_txn(1, 1, 1'b1, 1'b0, 1'b0);
        run_txn(4, 0, 1'b0, 1'b0, 1'b0);
        reset_mid();
        run_txn(2, 1, 1'b1, 1'b0, 1'b1);
        run_txn(0, 0, 1'b1, 1'b1, 1'b0);
        run_txn(15, 15, 1'b1, 1'b1, 1'b1);

        repeat (60) begin
            if ($urandom_range(0, 1) == 0) begin
                a05 = int'($urandom_range(0, 5));
                a10 = int'($urandom_range(0, 3));
            end else begin
                a05 = int'($urandom_range(0, 15));
                a10 = int'($urandom_range(0, 15));
            end
            run_txn(a05, a10, $urandom_range(0, 3) != 0, 1'b1, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
